// File: rtl/tx_pkg.sv
// ---------------------------------------------------------------------------
// tx_pkg
// Shared Tx-path types for the soft-value (LLR) datapath. The same word
// record is used by the Rx serial-to-parallel collector and its bench, so
// a word can be passed between the two without repacking.
//
// Contents:
//   LLR_W      width of one signed sample
//   LLR_N      samples per parallel word
//   llr_t      one signed sample
//   llr_word_t one parallel word of LLR_N samples plus packet/frame flags
// ---------------------------------------------------------------------------
package tx_pkg;

    localparam int LLR_W = 5;
    localparam int LLR_N = 8;

    typedef logic signed [LLR_W-1:0] llr_t;

    typedef struct {
        llr_t s [LLR_N];
        logic sop;
        logic eop;
        logic eof;
    } llr_word_t;

endpackage

// File: rtl/llr_demux.sv
// ---------------------------------------------------------------------------
// llr_demux
// Parallel-to-serial converter for the Tx path. Takes one word of N signed
// W-bit samples with packet flags and emits the samples one per cycle,
// element 0 first, under downstream backpressure. A one-word holding
// register in front of the shifting stage lets the next word be queued
// while the current one drains, so the output runs gap-free at full rate.
//
// Ports:
//   clk_h   in   clock
//   rst     in   asynchronous active-high reset
//   ival    in   input word valid
//   isop    in   word is first of packet
//   ieop    in   word is last of packet
//   ieof    in   word is last of frame
//   ibit    in   N x W signed parallel samples, ibit[0] emitted first
//   ordy    out  block can accept a word this cycle (registered)
//   oval    out  serial sample valid
//   osop    out  start of packet, on sample 0 of an isop word
//   oeop    out  end of packet, on sample N-1 of an ieop word
//   oeof    out  end of frame, on sample N-1 of an ieof word
//   obit    out  serial sample
//   iready  in   downstream accepts the sample this cycle
//
// The hold register and the stage use the shared llr_word_t record, so W
// and N must stay equal to LLR_W and LLR_N of tx_pkg.
// ---------------------------------------------------------------------------
module llr_demux
    import tx_pkg::*;
#(
    parameter int W = LLR_W,
    parameter int N = LLR_N
) (
    input  logic                clk_h,
    input  logic                rst,
    input  logic                ival,
    input  logic                isop,
    input  logic                ieop,
    input  logic                ieof,
    input  logic signed [W-1:0] ibit [0:N-1],
    output logic                ordy,
    output logic                oval,
    output logic                osop,
    output logic                oeop,
    output logic                oeof,
    output logic signed [W-1:0] obit,
    input  logic                iready
);

    localparam int             CW       = $clog2(N);
    localparam logic [CW-1:0]  LAST_IDX = CW'(N - 1);

    llr_word_t     r_hold;
    logic          r_holdValid;
    llr_word_t     r_stage;
    logic          r_stageValid;
    logic [CW-1:0] r_cnt;
    logic          r_ordy;

    logic w_accept;
    logic w_advance;
    logic w_lastOut;
    logic w_xfer;
    logic w_holdValidNext;

    // Handshake decode. A transfer from hold into the stage happens either
    // into an empty stage or on the very edge the stage hands off its last
    // sample, which is what keeps oval continuous across word boundaries.
    always_comb begin
        w_accept        = ival & r_ordy;
        w_advance       = r_stageValid & iready;
        w_lastOut       = w_advance & (r_cnt == LAST_IDX);
        w_xfer          = r_holdValid & (~r_stageValid | w_lastOut);
        w_holdValidNext = w_accept | (r_holdValid & ~w_xfer);
    end

    // Hold register. A new word may land on the same edge the old one moves
    // into the stage; the new word wins. ordy is the registered inverse of
    // the next hold-valid so it comes straight from a flop, and stays low
    // throughout reset.
    always_ff @(posedge clk_h or posedge rst) begin
        if (rst) begin
            r_holdValid <= 1'b0;
            r_ordy      <= 1'b0;
            r_hold.sop  <= 1'b0;
            r_hold.eop  <= 1'b0;
            r_hold.eof  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_hold.s[i] <= '0;
            end
        end else begin
            r_holdValid <= w_holdValidNext;
            r_ordy      <= ~w_holdValidNext;
            if (w_accept) begin
                r_hold.sop <= isop;
                r_hold.eop <= ieop;
                r_hold.eof <= ieof;
                for (int i = 0; i < N; i++) begin
                    r_hold.s[i] <= ibit[i];
                end
            end
        end
    end

    // Output stage. The counter selects the sample on the output; it only
    // moves when the downstream takes a sample, so a stall freezes both the
    // sample and the position-dependent flags. After the last sample the
    // stage either reloads from hold or drains empty.
    always_ff @(posedge clk_h or posedge rst) begin
        if (rst) begin
            r_stageValid <= 1'b0;
            r_cnt        <= '0;
            r_stage.sop  <= 1'b0;
            r_stage.eop  <= 1'b0;
            r_stage.eof  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_stage.s[i] <= '0;
            end
        end else begin
            if (w_xfer) begin
                r_stage      <= r_hold;
                r_stageValid <= 1'b1;
                r_cnt        <= '0;
            end else if (w_lastOut) begin
                r_stageValid <= 1'b0;
                r_cnt        <= '0;
            end else if (w_advance) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Serial outputs are forced to zero whenever no sample is presented so
    // stale stage contents never leak onto obit or the flags.
    always_comb begin
        ordy = r_ordy;
        oval = r_stageValid;
        obit = '0;
        osop = 1'b0;
        oeop = 1'b0;
        oeof = 1'b0;
        if (r_stageValid) begin
            obit = r_stage.s[r_cnt];
            osop = r_stage.sop & (r_cnt == '0);
            oeop = r_stage.eop & (r_cnt == LAST_IDX);
            oeof = r_stage.eof & (r_cnt == LAST_IDX);
        end
    end

endmodule

// File: tb/tb_llr_demux.sv
// ---------------------------------------------------------------------------
// tb_llr_demux
// Self-checking bench for llr_demux: per-cycle vector tables for a single
// word and a stalled word, then hand-written sequences for back-to-back
// words, randomised backpressure with a scoreboard, and reset mid-word.
// ---------------------------------------------------------------------------
module tb_llr_demux;

    localparam int W = 5;
    localparam int N = 8;

    logic                clk_h;
    logic                rst;
    logic                ival;
    logic                isop;
    logic                ieop;
    logic                ieof;
    logic signed [W-1:0] ibit [0:N-1];
    logic                ordy;
    logic                oval;
    logic                osop;
    logic                oeop;
    logic                oeof;
    logic signed [W-1:0] obit;
    logic                iready;

    int nChecks;
    int nFails;

    llr_demux #(.W(W), .N(N)) dut (
        .clk_h  (clk_h),
        .rst    (rst),
        .ival   (ival),
        .isop   (isop),
        .ieop   (ieop),
        .ieof   (ieof),
        .ibit   (ibit),
        .ordy   (ordy),
        .oval   (oval),
        .osop   (osop),
        .oeop   (oeop),
        .oeof   (oeof),
        .obit   (obit),
        .iready (iready)
    );

    initial clk_h = 1'b0;
    always #5 clk_h = ~clk_h;

    // One cycle of stimulus and the outputs expected during that cycle.
    typedef struct {
        logic       ival;
        logic       isop;
        logic       ieop;
        logic       ieof;
        logic       iready;
        logic [9:0] expOut;
    } vec_t;

    vec_t vecs [$];

    // Output bundle: {oval, obit[4:0], osop, oeop, oeof, ordy}
    function automatic logic [9:0] pack(input logic v, input int b, input logic s,
                                        input logic e, input logic f, input logic r);
        logic [4:0] bb;
        bb = 5'(b);
        return {v, bb, s, e, f, r};
    endfunction

    function automatic vec_t mk(input logic iv, input logic sp, input logic ep,
                                input logic ef, input logic rd, input logic [9:0] ex);
        vec_t v;
        v.ival   = iv;
        v.isop   = sp;
        v.ieop   = ep;
        v.ieof   = ef;
        v.iready = rd;
        v.expOut = ex;
        return v;
    endfunction

    function automatic logic [9:0] actOut();
        return {oval, obit, osop, oeop, oeof, ordy};
    endfunction

    task automatic applyStimulus(input vec_t v);
        ival   = v.ival;
        isop   = v.isop;
        ieop   = v.ieop;
        ieof   = v.ieof;
        iready = v.iready;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic loadWord(input int base);
        for (int i = 0; i < N; i++) begin
            ibit[i] = W'(base + i);
        end
    endtask

    task automatic loadWordA();
        logic signed [W-1:0] a [0:N-1];
        a = '{5'sd0, 5'sd1, 5'sd2, 5'sd3, -5'sd4, -5'sd3, -5'sd2, -5'sd1};
        for (int i = 0; i < N; i++) begin
            ibit[i] = a[i];
        end
    endtask

    // Waits at negedges until ordy is high, bounded so a stuck DUT still
    // reaches the summary.
    task automatic waitOrdy(input string name);
        int n;
        n = 0;
        while (ordy !== 1'b1 && n < 100) begin
            @(negedge clk_h);
            #1;
            n++;
        end
        if (ordy !== 1'b1) begin
            checkOutput({name, "_ordy_timeout"}, 32'(ordy), 32'd1);
        end
    endtask

    function automatic int b2bVal(input int k);
        return k - 16;
    endfunction

    logic [7:0] sbQ [$];

    initial begin
        nChecks = 0;
        nFails  = 0;
        rst     = 1'b1;
        ival    = 1'b0;
        isop    = 1'b0;
        ieop    = 1'b0;
        ieof    = 1'b0;
        iready  = 1'b1;
        loadWord(0);

        // ---------------- reset and idle ----------------
        repeat (2) @(negedge clk_h);
        #1;
        checkOutput("reset_outputs", 32'(actOut()), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("ordy_before_first_edge", 32'(ordy), 32'd0);
        @(negedge clk_h);
        #1;
        checkOutput("idle_after_first_edge", 32'(actOut()), 32'(pack(0, 0, 0, 0, 0, 1)));
        repeat (5) @(negedge clk_h);
        #1;
        checkOutput("idle_stays_quiet", 32'(actOut()), 32'(pack(0, 0, 0, 0, 0, 1)));

        // ---------------- vector tables ----------------
        // Single word A, isop & ieop, iready always high.
        vecs.push_back(mk(1, 1, 1, 0, 1, pack(0, 0, 0, 0, 0, 1)));
        vecs.push_back(mk(0, 0, 0, 0, 1, pack(0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 0, 0, 1, pack(1, 0, 1, 0, 0, 1)));
        vecs.push_back(mk(0, 0, 0, 0, 1, pack(1, 1, 0, 0, 0, 1)));
        vecs.push_back(mk(0, 0, 0, 0, 1, pack(1, 2, 0, 0, 0, 1)));
        vecs.push_back(mk(0, 0, 0, 0, 1, pack(1, 3, 0, 0, 0, 1)));
        vecs.push_back(mk(0, 0, 0, 0, 1, pack(1, -4, 0, 0, 0, 1)));
        vecs.push_back(mk(0, 0, 0, 0, 1, pack(1, -3, 0, 0, 0, 1)));
        vecs.push_back(mk(0, 0, 0, 0, 1, pack(1, -2, 0, 0, 0, 1)));
        vecs.push_back(mk(0, 0, 0, 0, 1, pack(1, -1, 0, 1, 0, 1)));
        vecs.push_back(mk(0, 0, 0, 0, 1, pack(0, 0, 0, 0, 0, 1)));
        // Word A again with all flags, stalled on sample 2 and on sample 7.
        vecs.push_back(mk(1, 1, 1, 1, 1, pack(0, 0, 0, 0, 0, 1)));
        vecs.push_back(mk(0, 0, 0, 0, 1, pack(0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 0, 0, 1, pack(1, 0, 1, 0, 0, 1)));
        vecs.push_back(mk(0, 0, 0, 0, 1, pack(1, 1, 0, 0, 0, 1)));
        vecs.push_back(mk(0, 0, 0, 0, 0, pack(1, 2, 0, 0, 0, 1)));
        vecs.push_back(mk(0, 0, 0, 0, 0, pack(1, 2, 0, 0, 0, 1)));
        vecs.push_back(mk(0, 0, 0, 0, 0, pack(1, 2, 0, 0, 0, 1)));
        vecs.push_back(mk(0, 0, 0, 0, 0, pack(1, 2, 0, 0, 0, 1)));
        vecs.push_back(mk(0, 0, 0, 0, 1, pack(1, 2, 0, 0, 0, 1)));
        vecs.push_back(mk(0, 0, 0, 0, 1, pack(1, 3, 0, 0, 0, 1)));
        vecs.push_back(mk(0, 0, 0, 0, 1, pack(1, -4, 0, 0, 0, 1)));
        vecs.push_back(mk(0, 0, 0, 0, 1, pack(1, -3, 0, 0, 0, 1)));
        vecs.push_back(mk(0, 0, 0, 0, 1, pack(1, -2, 0, 0, 0, 1)));
        vecs.push_back(mk(0, 0, 0, 0, 0, pack(1, -1, 0, 1, 1, 1)));
        vecs.push_back(mk(0, 0, 0, 0, 1, pack(1, -1, 0, 1, 1, 1)));
        vecs.push_back(mk(0, 0, 0, 0, 1, pack(0, 0, 0, 0, 0, 1)));

        loadWordA();
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk_h);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d", i), 32'(actOut()), 32'(vecs[i].expOut));
        end
        ival   = 1'b0;
        iready = 1'b1;

        // ---------------- back-to-back, 4 words ----------------
        begin
            int k;
            int gaps;
            bit started;
            k       = 0;
            gaps    = 0;
            started = 0;
            fork
                begin
                    for (int w = 0; w < 4; w++) begin
                        @(negedge clk_h);
                        #1;
                        waitOrdy("b2b");
                        loadWord(w * 8 - 16);
                        ival = 1'b1;
                        isop = (w == 0);
                        ieop = (w == 3);
                        ieof = (w == 3);
                        @(negedge clk_h);
                        #1;
                        ival = 1'b0;
                        isop = 1'b0;
                        ieop = 1'b0;
                        ieof = 1'b0;
                        checkOutput($sformatf("b2b_ordy_low_w%0d", w), 32'(ordy), 32'd0);
                    end
                end
                begin
                    for (int c = 0; c < 120 && k < 32; c++) begin
                        @(negedge clk_h);
                        #2;
                        if (oval) begin
                            started = 1;
                            checkOutput($sformatf("b2b_s%0d", k),
                                        32'({obit, osop, oeop, oeof}),
                                        32'({5'(b2bVal(k)), k == 0, k == 31, k == 31}));
                            k++;
                        end else if (started) begin
                            gaps++;
                        end
                    end
                end
            join
            checkOutput("b2b_sample_count", 32'(k), 32'd32);
            checkOutput("b2b_gap_cycles", 32'(gaps), 32'd0);
        end

        // ---------------- random backpressure, 100 words ----------------
        begin
            int consumed;
            consumed = 0;
            sbQ.delete();
            fork
                begin
                    for (int w = 0; w < 100; w++) begin
                        @(negedge clk_h);
                        #1;
                        repeat ($urandom_range(0, 3)) @(negedge clk_h);
                        #1;
                        waitOrdy("rnd");
                        ival = 1'b1;
                        isop = 1'($urandom_range(0, 1));
                        ieop = 1'($urandom_range(0, 1));
                        ieof = 1'($urandom_range(0, 1));
                        for (int i = 0; i < N; i++) begin
                            ibit[i] = W'($urandom_range(0, 31));
                            sbQ.push_back({isop & (i == 0), ieop & (i == N - 1),
                                           ieof & (i == N - 1), ibit[i]});
                        end
                        @(negedge clk_h);
                        #1;
                        ival = 1'b0;
                    end
                end
                begin
                    for (int c = 0; c < 6000 && consumed < 800; c++) begin
                        @(negedge clk_h);
                        iready = 1'($urandom_range(0, 1));
                        #2;
                        if (oval && iready) begin
                            if (sbQ.size() == 0) begin
                                checkOutput("rnd_unexpected_sample", 32'd1, 32'd0);
                            end else begin
                                checkOutput($sformatf("rnd_s%0d", consumed),
                                            32'({osop, oeop, oeof, obit}),
                                            32'(sbQ.pop_front()));
                            end
                            consumed++;
                        end
                    end
                end
            join
            checkOutput("rnd_sample_count", 32'(consumed), 32'd800);
            iready = 1'b1;
            repeat (3) @(negedge clk_h);
        end

        // ---------------- reset mid-word ----------------
        begin
            int stale;
            stale = 0;
            @(negedge clk_h);
            #1;
            waitOrdy("rstmid");
            loadWord(-8);
            ival = 1'b1;
            isop = 1'b1;
            @(negedge clk_h);
            ival = 1'b0;
            isop = 1'b0;
            @(negedge clk_h);
            #1;
            checkOutput("rstmid_s0", 32'({oval, obit}), 32'({1'b1, 5'(-8)}));
            loadWord(4);
            ival = 1'b1;
            @(negedge clk_h);
            ival = 1'b0;
            repeat (3) @(negedge clk_h);
            #1;
            checkOutput("rstmid_s4_hold_full", 32'({oval, obit, ordy}), 32'({1'b1, 5'(-4), 1'b0}));
            #1;
            rst = 1'b1;
            #1;
            checkOutput("rstmid_async_clear", 32'(actOut()), 32'd0);
            repeat (2) @(negedge clk_h);
            #2;
            rst = 1'b0;
            #1;
            checkOutput("rstmid_ordy_before_edge", 32'(ordy), 32'd0);
            @(negedge clk_h);
            #1;
            checkOutput("rstmid_ordy_after_edge", 32'(actOut()), 32'(pack(0, 0, 0, 0, 0, 1)));
            for (int c = 0; c < 12; c++) begin
                @(negedge clk_h);
                #1;
                if (oval) stale++;
            end
            checkOutput("rstmid_no_stale", 32'(stale), 32'd0);
            loadWord(10);
            ival = 1'b1;
            isop = 1'b1;
            @(negedge clk_h);
            ival = 1'b0;
            isop = 1'b0;
            @(negedge clk_h);
            #1;
            checkOutput("rstmid_new_s0", 32'({oval, obit, osop}), 32'({1'b1, 5'd10, 1'b1}));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
